// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one multi-cycle, stall-capable data memory between the
//             instruction-fetch port (IF, read only) and the memory-stage data
//             port (DM, read/write). One request is latched at a time. Ties
//             are broken round-robin. A watchdog completes a hung access with
//             zero read data and raises a sticky error flag.
//  Ports    : clk, rst_n           clock / asynchronous active-low reset
//             i_if_*  / o_if_*     fetch requester (req, addr, rdata, done, stall)
//             i_dm_*  / o_dm_*     data requester (req, wr, addr, wdata, rdata,
//                                  done, stall)
//             o_mem_* / i_mem_*    memory side (addr, wdata, rd, wr, rdata,
//                                  done, stall, err)
//             o_err                sticky error (memory error or timeout)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 63
) (
   input  logic              clk,
   input  logic              rst_n,
   // fetch port
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_done,
   output logic              o_if_stall,
   // data port
   input  logic              i_dm_req,
   input  logic              i_dm_wr,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_done,
   output logic              o_dm_stall,
   // memory side
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   input  logic [DATA_W-1:0] i_mem_rdata,
   input  logic              i_mem_done,
   input  logic              i_mem_stall,
   input  logic              i_mem_err,
   output logic              o_err
);

   localparam int               CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_wr_l;      // latched direction of the granted access
   logic              r_gnt_dm;    // 1 = DM owns the current transaction
   logic              r_last_dm;   // 1 = DM was granted most recently
   logic [CNT_W-1:0]  r_cnt;       // cycles spent in WAIT
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;
   logic              r_if_done;
   logic              r_dm_done;
   logic              r_err;

   logic              w_any_req;
   logic              w_pick_dm;
   logic              w_dm_write;
   logic              w_complete;
   logic              w_timeout;
   logic              w_finish;
   logic [DATA_W-1:0] w_cap_data;

   // DM wins when it is the only requester, or on a tie when IF went last.
   assign w_any_req  = i_if_req | i_dm_req;
   assign w_pick_dm  = i_dm_req & (~i_if_req | ~r_last_dm);
   assign w_dm_write = w_pick_dm & i_dm_wr;

   // mem_done is only meaningful once the memory has accepted (stall low).
   assign w_complete = ((r_state == S_ISSUE) & ~i_mem_stall & i_mem_done) |
                       ((r_state == S_WAIT) & i_mem_done);
   // Counter has already spent TIMEOUT cycles; this WAIT cycle is the last.
   assign w_timeout  = (r_state == S_WAIT) & ~i_mem_done & (r_cnt == C_TIMEOUT);
   assign w_finish   = w_complete | w_timeout;
   assign w_cap_data = w_timeout ? '0 : i_mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_l      <= 1'b0;
         r_gnt_dm    <= 1'b0;
         r_last_dm   <= 1'b0;
         r_cnt       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
         r_if_done   <= 1'b0;
         r_dm_done   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_if_done <= 1'b0;
         r_dm_done <= 1'b0;

         if (i_mem_err || w_timeout) begin
            r_err <= 1'b1;
         end

         // Completion: done pulse for the owner, read data for reads only.
         if (w_finish) begin
            if (r_gnt_dm) begin
               r_dm_done <= 1'b1;
               if (!r_wr_l) begin
                  r_dm_rdata <= w_cap_data;
               end
            end else begin
               r_if_done <= 1'b1;
               if (!r_wr_l) begin
                  r_if_rdata <= w_cap_data;
               end
            end
         end

         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_gnt_dm    <= w_pick_dm;
                  r_last_dm   <= w_pick_dm;
                  r_wr_l      <= w_dm_write;
                  r_mem_addr  <= w_pick_dm ? i_dm_addr : i_if_addr;
                  r_mem_wdata <= w_pick_dm ? i_dm_wdata : '0;
                  r_mem_rd    <= ~w_dm_write;
                  r_mem_wr    <= w_dm_write;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!i_mem_stall) begin
                  r_mem_rd <= 1'b0;
                  r_mem_wr <= 1'b0;
                  r_cnt    <= '0;
                  r_state  <= i_mem_done ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_finish) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_if_rdata  = r_if_rdata;
   assign o_if_done   = r_if_done;
   assign o_if_stall  = i_if_req & ~r_if_done;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_dm_done   = r_dm_done;
   assign o_dm_stall  = i_dm_req & ~r_dm_done;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_rd    = r_mem_rd;
   assign o_mem_wr    = r_mem_wr;
   assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter: a scripted memory
//             responder, a table of single transactions, hand-written
//             sequences for ties / timeout / error / reset, and a randomized
//             run checked against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk, rst_n;
   logic        if_req, if_done, if_stall;
   logic [15:0] if_addr, if_rdata;
   logic        dm_req, dm_wr, dm_done, dm_stall;
   logic [15:0] dm_addr, dm_wdata, dm_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err, err;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
      .o_if_done(if_done), .o_if_stall(if_stall),
      .i_dm_req(dm_req), .i_dm_wr(dm_wr), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .o_dm_rdata(dm_rdata), .o_dm_done(dm_done),
      .o_dm_stall(dm_stall),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_rd(mem_rd),
      .o_mem_wr(mem_wr), .i_mem_rdata(mem_rdata), .i_mem_done(mem_done),
      .i_mem_stall(mem_stall), .i_mem_err(mem_err), .o_err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass, n_total;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, act, exp);
   endtask

   // ---------------- memory responder ----------------
   int          cfg_stall, cfg_wait;
   bit          cfg_hang, cfg_err;
   logic [15:0] mem_arr [256];
   logic [15:0] ref_mem [256];

   initial begin : responder
      int st, wc;
      bit in_txn, acc, wr_t;
      logic [15:0] a_t, d_t;
      in_txn = 0; acc = 0; st = 0; wc = 0; wr_t = 0; a_t = 0; d_t = 0;
      mem_stall = 0; mem_done = 0; mem_err = 0; mem_rdata = 0;
      forever begin
         @(negedge clk);
         mem_done = 0; mem_err = 0; mem_stall = 0;
         mem_rdata = 16'($urandom);
         if (!rst_n) in_txn = 0;
         else if (in_txn && (if_done || dm_done)) in_txn = 0;
         else begin
            if (!in_txn && (mem_rd || mem_wr)) begin
               in_txn = 1; acc = 0; st = cfg_stall; wc = 0;
               a_t = mem_addr; wr_t = mem_wr; d_t = mem_wdata;
            end
            if (in_txn) begin
               if (!acc) begin
                  if (st > 0) begin mem_stall = 1; st--; end
                  else begin
                     acc = 1; mem_err = cfg_err;
                     if (cfg_wait == 0 && !cfg_hang) begin
                        mem_done = 1;
                        if (wr_t) mem_arr[a_t[7:0]] = d_t; else mem_rdata = mem_arr[a_t[7:0]];
                     end
                  end
               end else begin
                  wc++;
                  if (wc == cfg_wait && !cfg_hang) begin
                     mem_done = 1;
                     if (wr_t) mem_arr[a_t[7:0]] = d_t; else mem_rdata = mem_arr[a_t[7:0]];
                  end
               end
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      rst_n = 0; if_req = 0; dm_req = 0; dm_wr = 0;
      cfg_stall = 0; cfg_wait = 0; cfg_hang = 0; cfg_err = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   // Issue one request, wait for its done; reports latency (negedges from
   // request to done), strobe-high cycles and address/data stability.
   task automatic run_one(input bit dm, input bit wr, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output int strobes,
                          output bit stable);
      if (dm) begin dm_req = 1; dm_wr = wr; dm_addr = a; dm_wdata = d; end
      else begin if_req = 1; if_addr = a; end
      lat = 0; strobes = 0; stable = 1;
      while (lat < 40) begin
         @(negedge clk); lat++;
         if (mem_rd || mem_wr) strobes++;
         if (mem_rd && mem_wr) stable = 0;
         if (mem_addr !== a || (wr && mem_wdata !== d)) stable = 0;
         if (dm ? dm_done : if_done) break;
      end
      if_req = 0; dm_req = 0; dm_wr = 0;
   endtask

   typedef struct {
      bit dm; bit wr; logic [15:0] addr; logic [15:0] wdata;
      int stall; int wt; int lat; logic [15:0] rd; logic [15:0] oth;
   } vec_t;

   vec_t        vecs [7];
   int          lat, strobes;
   bit          stable;
   int          order [$];
   // random-model state
   bit          p_act [2];
   bit          p_wr  [2];
   logic [15:0] p_addr[2];
   logic [15:0] p_wd  [2];
   logic [15:0] exp_rd[2];
   int          last_w, cur, t_grant, lat_exp, ntx, stuck, w;
   int          c_stall, c_wait;
   bit          c_hang;

   initial begin
      n_pass = 0; n_total = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0;
      for (int i = 0; i < 256; i++) begin
         mem_arr[i] = 16'hA500 + 16'(i);
         ref_mem[i] = 16'hA500 + 16'(i);
      end
      rst_n = 0; if_req = 0; dm_req = 0; dm_wr = 0;
      cfg_stall = 0; cfg_wait = 0; cfg_hang = 0; cfg_err = 0;

      // ---- reset state ----
      @(negedge clk);
      chk("rst_strobes", {mem_rd, mem_wr}, 2'b00);
      chk("rst_done", {if_done, dm_done}, 2'b00);
      chk("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
      chk("rst_memaddr", {mem_addr, mem_wdata}, 32'h0);
      chk("rst_err", err, 1'b0);
      rst_n = 1;
      repeat (2) @(negedge clk);

      // ---- table of single transactions ----
      vecs[0] = '{1, 1, 16'h0040, 16'hBEEF, 0, 0, 2, 16'h0000, 16'h0000};
      vecs[1] = '{1, 0, 16'h0040, 16'h0000, 0, 0, 2, 16'hBEEF, 16'h0000};
      vecs[2] = '{0, 0, 16'h0040, 16'h0000, 0, 0, 2, 16'hBEEF, 16'hBEEF};
      vecs[3] = '{1, 0, 16'h0007, 16'h0000, 4, 3, 9, 16'hA507, 16'hBEEF};
      vecs[4] = '{0, 0, 16'h0012, 16'h0000, 1, 2, 5, 16'hA512, 16'hA507};
      vecs[5] = '{1, 1, 16'h0012, 16'h1234, 2, 1, 5, 16'hA507, 16'hA512};
      vecs[6] = '{0, 0, 16'h0012, 16'h0000, 0, 3, 5, 16'h1234, 16'hA507};
      for (int i = 0; i < 7; i++) begin
         cfg_stall = vecs[i].stall; cfg_wait = vecs[i].wt;
         run_one(vecs[i].dm, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, strobes, stable);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d_strobe_cycles", i), strobes, vecs[i].stall + 1);
         chk($sformatf("v%0d_addr_stable", i), stable, 1'b1);
         chk($sformatf("v%0d_rdata", i), vecs[i].dm ? dm_rdata : if_rdata, vecs[i].rd);
         chk($sformatf("v%0d_other_rdata", i), vecs[i].dm ? if_rdata : dm_rdata, vecs[i].oth);
         @(negedge clk);
         chk($sformatf("v%0d_done_one_cycle", i), {if_done, dm_done}, 2'b00);
      end
      chk("table_err", err, 1'b0);
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
      cfg_stall = 0; cfg_wait = 0;

      // ---- simultaneous requests from reset: DM, IF, DM, IF ----
      do_reset();
      if_addr = 16'h0010; dm_addr = 16'h0020; dm_wr = 0;
      if_req = 1; dm_req = 1;
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
         @(negedge clk);
         if (dm_done) begin order.push_back(1); chk("tie_loser_stall_if", {if_stall, dm_stall}, 2'b10); end
         if (if_done) begin order.push_back(0); chk("tie_loser_stall_dm", {if_stall, dm_stall}, 2'b01); end
      end
      if_req = 0; dm_req = 0;
      chk("tie_count", order.size(), 4);
      for (int k = 0; k < 4 && k < order.size(); k++)
         chk($sformatf("tie_order%0d", k), order[k], (k % 2 == 0) ? 1 : 0);
      chk("tie_if_rdata", if_rdata, 16'hA510);
      chk("tie_dm_rdata", dm_rdata, 16'hA520);
      repeat (2) @(negedge clk);

      // ---- watchdog timeout ----
      chk("to_err_before", err, 1'b0);
      cfg_hang = 1;
      run_one(0, 0, 16'h0033, 16'h0, lat, strobes, stable);
      chk("to_latency", lat, 2 + TO + 1);
      chk("to_if_rdata", if_rdata, 16'h0000);
      chk("to_err", err, 1'b1);
      @(negedge clk);
      cfg_hang = 0;
      run_one(1, 0, 16'h0021, 16'h0, lat, strobes, stable);
      chk("after_to_latency", lat, 2);
      chk("after_to_rdata", dm_rdata, 16'hA521);
      chk("after_to_err_sticky", err, 1'b1);
      @(negedge clk);

      // ---- mem_err pulse during a read ----
      do_reset();
      chk("merr_cleared_by_reset", err, 1'b0);
      cfg_err = 1;
      run_one(1, 0, 16'h0005, 16'h0, lat, strobes, stable);
      cfg_err = 0;
      chk("merr_rdata", dm_rdata, 16'hA505);
      chk("merr_latency", lat, 2);
      repeat (3) @(negedge clk);
      chk("merr_err_sticky", err, 1'b1);

      // ---- reset mid-WAIT ----
      cfg_hang = 1;
      dm_req = 1; dm_wr = 0; dm_addr = 16'h0066;
      repeat (3) @(negedge clk);
      chk("rw_in_wait_addr", mem_addr, 16'h0066);
      #2 rst_n = 0; dm_req = 0;
      #1;
      chk("rw_async_strobes", {mem_rd, mem_wr}, 2'b00);
      chk("rw_async_addr", mem_addr, 16'h0000);
      chk("rw_async_rdata", dm_rdata, 16'h0000);
      chk("rw_async_err", err, 1'b0);
      repeat (2) begin
         @(negedge clk);
         chk("rw_no_done", {if_done, dm_done}, 2'b00);
      end
      rst_n = 1; cfg_hang = 0;
      if_addr = 16'h0001; dm_addr = 16'h0002; if_req = 1; dm_req = 1;
      lat = 0;
      while (lat < 10 && !if_done && !dm_done) begin @(negedge clk); lat++; end
      chk("rw_first_tie_dm", {if_done, dm_done}, 2'b01);
      if_req = 0; dm_req = 0;
      repeat (6) @(negedge clk);

      // ---- randomized run against a transaction-level model ----
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = mem_arr[i];
      for (int p = 0; p < 2; p++) begin p_act[p] = 0; p_wr[p] = 0; p_addr[p] = 0; p_wd[p] = 0; exp_rd[p] = 0; end
      last_w = 0; cur = -1; ntx = 0; stuck = 0; t_grant = 0; lat_exp = 0;
      c_stall = 0; c_wait = 0; c_hang = 0;
      for (int cyc = 0; cyc < 4000 && ntx < 150; cyc++) begin
         @(negedge clk);
         stuck++;
         if (cur < 0 && (mem_rd || mem_wr)) begin
            w = (p_act[0] && p_act[1]) ? 1 - last_w : (p_act[1] ? 1 : 0);
            chk("rnd_grant_has_req", p_act[w], 1'b1);
            chk("rnd_grant_addr", mem_addr, p_addr[w]);
            chk("rnd_grant_dir", {mem_wr, mem_rd}, p_wr[w] ? 2'b10 : 2'b01);
            if (p_wr[w]) chk("rnd_grant_wdata", mem_wdata, p_wd[w]);
            last_w = w; cur = w; t_grant = cyc; stuck = 0;
            lat_exp = 1 + c_stall + (c_hang ? TO + 1 : c_wait);
         end
         chk("rnd_stall_if", if_stall, if_req & ~if_done);
         chk("rnd_stall_dm", dm_stall, dm_req & ~dm_done);
         if (if_done || dm_done) begin
            chk("rnd_done_owner", {dm_done, if_done}, (cur == 1) ? 2'b10 : 2'b01);
            chk("rnd_latency", cyc - t_grant, lat_exp);
            if (cur >= 0) begin
               if (p_wr[cur]) begin
                  if (!c_hang) ref_mem[p_addr[cur][7:0]] = p_wd[cur];
               end else begin
                  exp_rd[cur] = c_hang ? 16'h0 : ref_mem[p_addr[cur][7:0]];
               end
               p_act[cur] = 0;
            end
            chk("rnd_if_rdata", if_rdata, exp_rd[0]);
            chk("rnd_dm_rdata", dm_rdata, exp_rd[1]);
            cur = -1; ntx++; stuck = 0;
            c_stall = $urandom_range(0, 2);
            c_wait  = $urandom_range(0, 2);
            c_hang  = ($urandom_range(0, 9) == 0);
            cfg_stall = c_stall; cfg_wait = c_wait; cfg_hang = c_hang;
         end
         if (stuck > 40) begin
            n_total++;
            $display("FAIL rnd_progress: no grant or done for %0d cycles, want at most 40", stuck);
            break;
         end
         for (int p = 0; p < 2; p++) begin
            if (!p_act[p] && $urandom_range(0, 1) == 1) begin
               p_act[p] = 1;
               p_addr[p] = 16'($urandom_range(0, 15));
               p_wr[p] = (p == 1) && ($urandom_range(0, 2) == 0);
               p_wd[p] = 16'($urandom);
            end
         end
         if_req = p_act[0]; if_addr = p_addr[0];
         dm_req = p_act[1]; dm_addr = p_addr[1]; dm_wr = p_wr[1]; dm_wdata = p_wd[1];
      end
      chk("rnd_tx_count", ntx >= 150, 1'b1);
      if_req = 0; dm_req = 0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single multi-cycle, stall-capable data memory (Done/Stall/err handshake) between two requesters: instruction fetch (IF port) and the memory stage data access (DM port). It latches one request at a time, drives the memory, waits for completion, and returns read data with a one-cycle done pulse to the winner. Round-robin arbitration on ties and a watchdog timeout keep a slow or hung memory from deadlocking the pipeline. It sits between fetch/memory stages and the memory instance.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 63, max cycles in WAIT before watchdog error (≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, registered
- if_done  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_done
- dm_req  in  1  data request, held until dm_done
- dm_wr  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  data read data, registered
- dm_done  out  1  one-cycle completion pulse for data
- dm_stall  out  1  dm_req & ~dm_done
- mem_addr, mem_wdata  out  ADDR_W/DATA_W  to memory, from latched request
- mem_rd, mem_wr  out  1  memory strobes, high only in ISSUE
- mem_rdata  in  DATA_W  memory read data, valid with mem_done
- mem_done  in  1  memory completion
- mem_stall  in  1  memory busy; request not accepted while high
- mem_err  in  1  memory error
- err  out  1  sticky error flag

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, select winner, latch addr, wdata, wr (IF is always read), and grant id into registers; go to ISSUE. Otherwise stay.
- Arbitration: one requester pending → it wins. Both pending → the requester not granted last wins. last_grant resets to IF, so the first tie goes to DM. last_grant updates on every IDLE→ISSUE.
- ISSUE: mem_rd = ~wr_l and mem_wr = wr_l, with mem_addr/mem_wdata from the latched registers.
  - mem_stall high → stay in ISSUE.
  - mem_stall low and mem_done high → complete (see below) and go to RESP.
  - mem_stall low and mem_done low → go to WAIT and clear the timeout counter.
- WAIT: strobes low, outputs held.
  - mem_done → complete and go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT, set err, complete with rdata = 0, and go to RESP.
- Complete: for a read, load the granted port's rdata register with mem_rdata. For a write, rdata is unchanged. Assert the granted port's done register (high during RESP).
- RESP: done high for exactly this cycle; next state is IDLE. Requesters deassert or replace req at the edge ending RESP.
- Dropped request: a requester that drops req after grant still has its transaction completed and its done pulsed. Writes are never cancelled.
- err: set by mem_err sampled high in any state, or by timeout; cleared only by reset. Operation continues normally after err.
- Only one memory transaction is outstanding; the non-granted requester waits with stall high.

## Timing
- Reset (async, rst low): state IDLE; if_rdata = dm_rdata = 0; if_done = dm_done = 0; mem_rd = mem_wr = 0; mem_addr = mem_wdata = 0; err = 0; last_grant = IF; counter = 0. Strobes must drop immediately on reset assertion, including mid-transaction. The in-flight transaction is abandoned with no done pulse.
- Minimum latency: req high at edge E0 (IDLE) → strobe during E0–E1 → accept and mem_done at E1 → done and rdata valid during E1–E2 → IDLE at E2 → next grant sampled at E3. Peak throughput is one transaction per 3 cycles.
- Each stall cycle in ISSUE and each WAIT cycle adds one cycle.
- Timeout: done is asserted TIMEOUT+1 cycles after entering WAIT.
- mem_rd and mem_wr are never both high. No strobe is driven outside ISSUE.
- if_stall and dm_stall are combinational.

## Test plan
- Single DM write, then read: dm_wr=1, addr 0x0040, wdata 0xBEEF, memory done on accept → dm_done pulses 2 cycles after req. The read of 0x0040 returns dm_rdata = 0xBEEF and leaves if_rdata = 0.
- Simultaneous requests from reset: if_req and dm_req both held → grant order DM, IF, DM, IF. Each done pulses once per transaction; the loser's stall stays high until its done.
- Memory stall: mem_stall high 4 cycles during ISSUE, then mem_done after 3 WAIT cycles → mem_rd held high exactly 5 cycles. dm_done arrives 9 cycles after req. Addr and wdata stay stable throughout.
- Timeout: TIMEOUT = 4, memory never raises done → err rises and if_done pulses with if_rdata = 0 five cycles after entering WAIT. A following request completes normally while err stays 1.
- Reset mid-WAIT: drop rst during WAIT → all outputs at reset values asynchronously, with no done pulse. After release, the first tie grants DM.
- mem_err pulse during a read: err is set and stays high. The read still completes with mem_rdata captured.
